// File: rtl/mux_arb_pkg.sv
// Shared definitions for the round-robin mux arbiter.
package mux_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    localparam int N_REQ = 4;
    localparam int SEL_W = 2;

endpackage

// File: rtl/dec2to4.sv
// 2-to-4 decoder with enable. The output is numbered y[0:3], so W=0 lights the
// leftmost bit when the vector is read as [3:0].
module dec2to4 (
    input  logic [1:0] W,
    input  logic       En,
    output logic [0:3] Y
);

    // One-hot decode, all zero when disabled
    always_comb begin
        Y = '0;
        if (En) begin
            Y[W] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_pick4.sv
// Round-robin pick: scans Last+1, Last+2, Last+3 and then Last itself.
// With Excl set, Last is skipped so the current owner cannot win again.
module rr_pick4
    import mux_arb_pkg::*;
(
    input  logic [N_REQ-1:0] Req,
    input  logic [SEL_W-1:0] Last,
    input  logic             Excl,
    output logic [SEL_W-1:0] Pick,
    output logic             Found
);

    logic [SEL_W-1:0] idx;

    // First set request in rotating order wins
    always_comb begin
        Pick  = '0;
        Found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = Last + SEL_W'(i);
            if (!Found && Req[idx] && !(i == N_REQ && Excl)) begin
                Pick  = idx;
                Found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter sharing one 4:1 data mux. Holds the owner FSM, the
// round-robin pointer, the hold counter and the registered mux output.
//
// state   | meaning
// ST_IDLE | no owner, Busy=0, Grant=0000
// ST_OWN  | Sel owns the mux, Busy=1, Cnt counts held cycles
module rr_mux_arbiter
    import mux_arb_pkg::*;
#(
    parameter int DW       = 1,
    parameter int MAX_HOLD = 8
) (
    input  logic                Clock,
    input  logic                Resetn,
    input  logic                En,
    input  logic [N_REQ-1:0]    Req,
    input  logic [N_REQ*DW-1:0] W,
    output logic [SEL_W-1:0]    Sel,
    output logic [N_REQ-1:0]    Grant,
    output logic                Busy,
    output logic [DW-1:0]       F,
    output logic                Fvalid
);

    localparam int CNT_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_HOLD - 1);

    state_t           state_q, state_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [SEL_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]    f_q, f_d;
    logic             fvalid_q, fvalid_d;

    logic [SEL_W-1:0] pick;
    logic             found;
    logic [0:3]       dec_y;

    // While owning, the current owner (== Last) is excluded from the scan.
    // On a release its Req is already low, so exclusion changes nothing there.
    rr_pick4 u_pick (
        .Req   (Req),
        .Last  (last_q),
        .Excl  (state_q == ST_OWN),
        .Pick  (pick),
        .Found (found)
    );

    dec2to4 u_dec (
        .W  (sel_q),
        .En (state_q == ST_OWN),
        .Y  (dec_y)
    );

    // Next-state, ownership and datapath decisions
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        f_d      = (state_q == ST_OWN) ? W[int'(sel_q)*DW +: DW] : '0;
        fvalid_d = (state_q == ST_OWN);
        case (state_q)
            ST_IDLE: begin
                if (En && found) begin
                    state_d = ST_OWN;
                    sel_d   = pick;
                    last_d  = pick;
                    cnt_d   = '0;
                end
            end
            ST_OWN: begin
                if (!En) begin
                    state_d = ST_IDLE;
                end else if (!Req[sel_q]) begin
                    if (found) begin
                        sel_d  = pick;
                        last_d = pick;
                        cnt_d  = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (cnt_q == CNT_MAX && found) begin
                    sel_d  = pick;
                    last_d = pick;
                    cnt_d  = '0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; Last resets to 3 so requester 0 leads
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q  <= ST_IDLE;
            sel_q    <= '0;
            last_q   <= SEL_W'(N_REQ - 1);
            cnt_q    <= '0;
            f_q      <= '0;
            fvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            f_q      <= f_d;
            fvalid_q <= fvalid_d;
        end
    end

    assign Sel    = sel_q;
    assign Busy   = (state_q == ST_OWN);
    assign Grant  = dec_y;
    assign F      = f_q;
    assign Fvalid = fvalid_q;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed bench for rr_mux_arbiter (DW=4, MAX_HOLD=8).
module tb_rr_mux_arbiter;

    localparam int DW = 4;

    logic          Clock;
    logic          Resetn;
    logic          En;
    logic [3:0]    Req;
    logic [4*DW-1:0] W;
    logic [1:0]    Sel;
    logic [3:0]    Grant;
    logic          Busy;
    logic [DW-1:0] F;
    logic          Fvalid;

    int checks   = 0;
    int failures = 0;

    rr_mux_arbiter #(.DW(DW), .MAX_HOLD(8)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .En     (En),
        .Req    (Req),
        .W      (W),
        .Sel    (Sel),
        .Grant  (Grant),
        .Busy   (Busy),
        .F      (F),
        .Fvalid (Fvalid)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Expected owner outputs: Grant is dec2to4 order, owner 0 -> 1000
    task automatic chk_own(input string tag, input int own);
        logic [3:0] g;
        g = 4'b1000 >> own;
        chk({tag, "_sel"}, 32'(Sel), 32'(own));
        chk({tag, "_busy"}, 32'(Busy), 32'd1);
        chk({tag, "_grant"}, 32'(Grant), 32'(g));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, 32'(Busy), 32'd0);
        chk({tag, "_grant"}, 32'(Grant), 32'd0);
    endtask

    initial begin
        int prev;
        Resetn = 1'b0;
        En     = 1'b0;
        Req    = 4'b0000;
        W      = 16'h4321;   // W[i] = i+1
        #12;
        chk("rst_sel", 32'(Sel), 32'd0);
        chk_idle("rst");
        chk("rst_f", 32'(F), 32'd0);
        chk("rst_fvalid", 32'(Fvalid), 32'd0);

        // 1: single requester 0
        Resetn = 1'b1;
        Req = 4'b0001;
        En  = 1'b1;
        tick();
        chk_own("t1", 0);
        chk("t1_fvalid0", 32'(Fvalid), 32'd0);
        tick();
        chk("t1_fvalid1", 32'(Fvalid), 32'd1);
        chk("t1_f", 32'(F), 32'h1);

        // 2: all requesting, rotation 0,1,2,3,0 with eight cycles each
        #2 Resetn = 1'b0;
        #1 Resetn = 1'b1;
        Req  = 4'b1111;
        prev = -1;
        for (int o = 0; o < 5; o++) begin
            for (int c = 0; c < 8; c++) begin
                tick();
                chk_own("t2", o % 4);
                chk("t2_fvalid", 32'(Fvalid), (prev < 0) ? 32'd0 : 32'd1);
                chk("t2_f", 32'(F), (prev < 0) ? 32'd0 : 32'(prev + 1));
                prev = o % 4;
            end
        end

        // 3: owner releases
        Req = 4'b0100;
        tick();
        chk_own("t3_to2", 2);
        Req = 4'b0010;
        tick();
        chk_own("t3_to1", 1);
        Req = 4'b0100;
        tick();
        chk_own("t3_back2", 2);
        Req = 4'b0000;
        tick();
        chk_idle("t3_idle");
        chk("t3_f_last", 32'(F), 32'h3);
        chk("t3_fvalid_last", 32'(Fvalid), 32'd1);
        tick();
        chk("t3_f0", 32'(F), 32'd0);
        chk("t3_fvalid0", 32'(Fvalid), 32'd0);

        // 4: sole requester holds indefinitely, then preemption
        Req = 4'b0100;
        for (int c = 0; c < 20; c++) begin
            tick();
            chk_own("t4_hold", 2);
        end
        Req = 4'b0101;
        tick();
        chk_own("t4_preempt", 0);
        for (int c = 0; c < 7; c++) begin
            tick();
            chk_own("t4_own0", 0);
        end
        tick();
        chk_own("t4_back2", 2);

        // 5: enable low releases and blocks new grants
        En = 1'b0;
        tick();
        chk_idle("t5_off");
        Req = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk_idle("t5_blocked");
        end
        En = 1'b1;
        tick();
        chk_own("t5_on", 3);

        // 6: async reset mid-ownership
        tick();
        chk_own("t6_own3", 3);
        chk("t6_f", 32'(F), 32'h4);
        chk("t6_fvalid", 32'(Fvalid), 32'd1);
        #3 Resetn = 1'b0;
        #1;
        chk_idle("t6_rst");
        chk("t6_rst_sel", 32'(Sel), 32'd0);
        chk("t6_rst_f", 32'(F), 32'd0);
        chk("t6_rst_fvalid", 32'(Fvalid), 32'd0);
        Req = 4'b1001;
        Resetn = 1'b1;
        tick();
        chk_own("t6_after", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
